// File: rtl/bp_update_queue.sv
// Coalescing write-back queue between branch resolution and a single-port predictor RAM.
// Latency: an accepted update is visible on lookup and can be written one cycle after its enqueue edge.
// Backpressure: enqReady uses the registered count. Updates offered while it is low are dropped and counted.
module bp_update_queue #(
    parameter int DEPTH       = 32,
    parameter int ENQ_WIDTH   = 2,
    parameter int INDEX_WIDTH = 10,
    parameter int VALUE_WIDTH = 2,
    parameter int COALESCE    = 1,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [ENQ_WIDTH-1:0]                  enqValid,
    input  logic [ENQ_WIDTH-1:0][INDEX_WIDTH-1:0] enqIndex,
    input  logic [ENQ_WIDTH-1:0][VALUE_WIDTH-1:0] enqValue,
    output logic                                  enqReady,
    input  logic                                  portBusy,
    output logic                                  wrValid,
    output logic [INDEX_WIDTH-1:0]                wrIndex,
    output logic [VALUE_WIDTH-1:0]                wrValue,
    input  logic [INDEX_WIDTH-1:0]                lookupIndex,
    output logic                                  lookupHit,
    output logic [VALUE_WIDTH-1:0]                lookupValue,
    output logic [CW-1:0]                         count,
    output logic                                  empty,
    output logic                                  full,
    output logic [7:0]                            dropCount
);

    typedef struct packed {
        logic                   vld;
        logic [INDEX_WIDTH-1:0] idx;
        logic [VALUE_WIDTH-1:0] val;
    } entry_t;

    entry_t         ent    [DEPTH];
    entry_t         entNxt [DEPTH];
    logic [PW-1:0]  head, tail, headNxt, tailNxt, slot;
    logic [CW-1:0]  countNxt, allocCnt;
    logic [7:0]     dropNxt;
    logic [8:0]     dropSum;
    logic [ENQ_WIDTH-1:0] survive, mergeHit;
    logic [PW-1:0]  mergeSlot [ENQ_WIDTH];
    logic [PW-1:0]  lkAge, lkBest;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign enqReady = (count <= CW'(DEPTH - ENQ_WIDTH));
    assign wrValid  = !empty && !portBusy;
    assign wrIndex  = ent[head].idx;
    assign wrValue  = ent[head].val;

    // A lane survives unless a younger lane in the same cycle targets the same index.
    always_comb begin
        for (int l = 0; l < ENQ_WIDTH; l++) begin
            survive[l] = enqValid[l];
            if (COALESCE != 0) begin
                for (int m = l + 1; m < ENQ_WIDTH; m++) begin
                    if (enqValid[m] && (enqIndex[m] == enqIndex[l])) survive[l] = 1'b0;
                end
            end
        end
    end

    // The departing head must not absorb a merge, or the new value would never reach the RAM.
    always_comb begin
        for (int l = 0; l < ENQ_WIDTH; l++) begin
            mergeHit[l]  = 1'b0;
            mergeSlot[l] = '0;
            if ((COALESCE != 0) && survive[l]) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (ent[e].vld && (ent[e].idx == enqIndex[l]) &&
                        !(wrValid && (PW'(e) == head))) begin
                        mergeHit[l]  = 1'b1;
                        mergeSlot[l] = PW'(e);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++) entNxt[e] = ent[e];
        allocCnt = '0;
        slot     = '0;
        dropSum  = {1'b0, dropCount};
        if (wrValid) entNxt[head].vld = 1'b0;
        if (enqReady) begin
            for (int l = 0; l < ENQ_WIDTH; l++) begin
                if (survive[l]) begin
                    if (mergeHit[l]) begin
                        entNxt[mergeSlot[l]].val = enqValue[l];
                    end else begin
                        slot         = tail + allocCnt[PW-1:0];
                        entNxt[slot] = '{vld: 1'b1, idx: enqIndex[l], val: enqValue[l]};
                        allocCnt     = allocCnt + 1'b1;
                    end
                end
            end
        end else begin
            for (int l = 0; l < ENQ_WIDTH; l++) dropSum = dropSum + {8'd0, enqValid[l]};
        end
        dropNxt  = (dropSum > 9'd255) ? 8'd255 : dropSum[7:0];
        countNxt = count + allocCnt - {{(CW-1){1'b0}}, wrValid};
        tailNxt  = tail + allocCnt[PW-1:0];
        headNxt  = head + {{(PW-1){1'b0}}, wrValid};
    end

    // Youngest match is the one furthest from the head; matters only without coalescing.
    always_comb begin
        lookupHit   = 1'b0;
        lookupValue = '0;
        lkBest      = '0;
        lkAge       = '0;
        for (int e = 0; e < DEPTH; e++) begin
            lkAge = PW'(e) - head;
            if (ent[e].vld && (ent[e].idx == lookupIndex) && (!lookupHit || (lkAge > lkBest))) begin
                lookupHit   = 1'b1;
                lookupValue = ent[e].val;
                lkBest      = lkAge;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            dropCount <= '0;
            for (int e = 0; e < DEPTH; e++) ent[e] <= '0;
        end else begin
            head      <= headNxt;
            tail      <= tailNxt;
            count     <= countNxt;
            dropCount <= dropNxt;
            for (int e = 0; e < DEPTH; e++) ent[e] <= entNxt[e];
        end
    end

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue; expected RAM writes are queued and checked by a separate monitor.
module tb_bp_update_queue;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       enqValid;
    logic [1:0][9:0]  enqIndex;
    logic [1:0][1:0]  enqValue;
    logic             enqReady;
    logic             portBusy;
    logic             wrValid;
    logic [9:0]       wrIndex;
    logic [1:0]       wrValue;
    logic [9:0]       lookupIndex;
    logic             lookupHit;
    logic [1:0]       lookupValue;
    logic [5:0]       count;
    logic             empty, full;
    logic [7:0]       dropCount;

    typedef struct packed {
        logic [9:0] idx;
        logic [1:0] val;
    } wr_t;

    wr_t expQ[$];
    int  tests = 0;
    int  fails = 0;

    bp_update_queue dut (
        .clk(clk), .rst(rst),
        .enqValid(enqValid), .enqIndex(enqIndex), .enqValue(enqValue), .enqReady(enqReady),
        .portBusy(portBusy),
        .wrValid(wrValid), .wrIndex(wrIndex), .wrValue(wrValue),
        .lookupIndex(lookupIndex), .lookupHit(lookupHit), .lookupValue(lookupValue),
        .count(count), .empty(empty), .full(full), .dropCount(dropCount)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lanes(input logic [1:0] v, input logic [9:0] i0, input logic [1:0] v0,
                         input logic [9:0] i1, input logic [1:0] v1);
        enqValid    = v;
        enqIndex[0] = i0;
        enqValue[0] = v0;
        enqIndex[1] = i1;
        enqValue[1] = v1;
    endtask

    task automatic pushExp(input logic [9:0] i, input logic [1:0] v);
        wr_t w;
        w.idx = i;
        w.val = v;
        expQ.push_back(w);
    endtask

    // Monitor: every RAM write must match the oldest outstanding expectation.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && wrValid === 1'b1) begin
                if (expQ.size() == 0) begin
                    check("unexpected_write", {22'd0, wrIndex}, 32'hFFFF);
                end else begin
                    w = expQ.pop_front();
                    check("wr_index", {22'd0, wrIndex}, {22'd0, w.idx});
                    check("wr_value", {30'd0, wrValue}, {30'd0, w.val});
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        portBusy = 1'b0;
        lookupIndex = '0;
        lanes(2'b00, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;

        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_enqReady", enqReady, 1);
        check("rst_wrValid", wrValid, 0);
        check("rst_lookupHit", lookupHit, 0);
        check("rst_dropCount", dropCount, 0);

        // Single update reaches the RAM one cycle later.
        lanes(2'b01, 10'd5, 2'd3, 0, 0);
        pushExp(10'd5, 2'd3);
        step();
        lanes(2'b00, 0, 0, 0, 0);
        check("t1_wrValid", wrValid, 1);
        check("t1_wrIndex", wrIndex, 5);
        check("t1_wrValue", wrValue, 3);
        step();
        check("t1_empty", empty, 1);

        // Fill to DEPTH while stalled, then overflow.
        portBusy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            lanes(2'b11, 10'(100 + 2 * i), 2'(i), 10'(101 + 2 * i), 2'(i + 1));
            pushExp(10'(100 + 2 * i), 2'(i));
            pushExp(10'(101 + 2 * i), 2'(i + 1));
            step();
        end
        lanes(2'b00, 0, 0, 0, 0);
        check("fill_count", count, 32);
        check("fill_full", full, 1);
        check("fill_enqReady", enqReady, 0);
        lanes(2'b11, 10'd200, 2'd1, 10'd201, 2'd2);
        step();
        lanes(2'b00, 0, 0, 0, 0);
        check("drop_dropCount", dropCount, 2);
        check("drop_count", count, 32);
        portBusy = 1'b0;
        for (int i = 0; i < 32; i++) step();
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);

        // Queue merge into an existing entry.
        portBusy = 1'b1;
        lanes(2'b01, 10'd7, 2'd1, 0, 0);
        step();
        lanes(2'b00, 0, 0, 0, 0);
        step();
        lanes(2'b10, 0, 0, 10'd7, 2'd2);
        step();
        lanes(2'b00, 0, 0, 0, 0);
        pushExp(10'd7, 2'd2);
        lookupIndex = 10'd7;
        #1;
        check("qmerge_count", count, 1);
        check("qmerge_hit", lookupHit, 1);
        check("qmerge_value", lookupValue, 2);
        lookupIndex = 10'd8;
        #1;
        check("qmerge_miss", lookupHit, 0);

        // Same-cycle merge: lane1 wins, nothing dropped.
        lanes(2'b11, 10'd9, 2'd0, 10'd9, 2'd3);
        pushExp(10'd9, 2'd3);
        step();
        lanes(2'b00, 0, 0, 0, 0);
        lookupIndex = 10'd9;
        #1;
        check("imerge_count", count, 2);
        check("imerge_drop", dropCount, 2);
        check("imerge_hit", lookupHit, 1);
        check("imerge_value", lookupValue, 3);
        portBusy = 1'b0;
        step();
        step();
        check("imerge_empty", empty, 1);

        // Draining head is excluded from merging.
        portBusy = 1'b1;
        lanes(2'b01, 10'd4, 2'd1, 0, 0);
        pushExp(10'd4, 2'd1);
        step();
        portBusy = 1'b0;
        lanes(2'b01, 10'd4, 2'd2, 0, 0);
        pushExp(10'd4, 2'd2);
        step();
        lanes(2'b00, 0, 0, 0, 0);
        check("head_count", count, 1);
        check("head_wrIndex", wrIndex, 4);
        check("head_wrValue", wrValue, 2);
        step();
        check("head_empty", empty, 1);

        // Reset mid-operation discards queued entries.
        portBusy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lanes(2'b11, 10'(300 + 2 * i), 2'd1, 10'(301 + 2 * i), 2'd2);
            step();
        end
        lanes(2'b00, 0, 0, 0, 0);
        check("pre_rst_count", count, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        portBusy = 1'b0;
        lookupIndex = 10'd300;
        #1;
        check("mrst_count", count, 0);
        check("mrst_wrValid", wrValid, 0);
        check("mrst_lookupHit", lookupHit, 0);
        check("mrst_dropCount", dropCount, 0);
        step();
        step();

        check("exp_queue_drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bp_update_queue.md
# bp_update_queue

Parametrised write-back queue for branch-predictor counter tables (PHT, and BTB-style tables with a wider value). It sits between branch resolution and a single-port predictor RAM: it absorbs up to ENQ_WIDTH counter updates per cycle and drains one per cycle into the RAM whenever fetch is not reading the RAM. Queued updates to the same index are coalesced, and a lookup port forwards the youngest pending value so fetch never reads a stale counter.

## Interface
- DEPTH, 32: queue entries; power of two, >= ENQ_WIDTH.
- ENQ_WIDTH, 2: update lanes per cycle; lane ENQ_WIDTH-1 is youngest.
- INDEX_WIDTH, 10: table index width.
- VALUE_WIDTH, 2: stored value width (2 = PHT counter).
- COALESCE, 1: 1 enables same-index merging; 0 is a plain FIFO.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- enqValid  in  ENQ_WIDTH  per-lane update request.
- enqIndex  in  ENQ_WIDTH x INDEX_WIDTH  per-lane table index.
- enqValue  in  ENQ_WIDTH x VALUE_WIDTH  per-lane new value.
- enqReady  out  1  free entries >= ENQ_WIDTH; sampled by the producer in the same cycle.
- portBusy  in  1  RAM port is used by fetch this cycle; no drain.
- wrValid  out  1  write head entry to RAM this cycle; RAM always accepts.
- wrIndex  out  INDEX_WIDTH  head index.
- wrValue  out  VALUE_WIDTH  head value.
- lookupIndex  in  INDEX_WIDTH  fetch-side read index.
- lookupHit  out  1  a queued entry matches lookupIndex.
- lookupValue  out  VALUE_WIDTH  value of the youngest matching entry.
- count  out  $clog2(DEPTH+1)  occupied entries.
- empty, full  out  1 each  count==0 / count==DEPTH.
- dropCount  out  8  saturating count of discarded lane updates.

## Operation
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits; pointers wrap DEPTH-1 -> 0. Each entry holds a valid bit, index and value.
- Drain: wrValid = !empty && !portBusy. When wrValid is high, the head is dequeued at the clock edge.
- Enqueue is accepted only when enqReady=1. When enqReady=0, every valid lane is discarded and dropCount increases by the number of valid lanes, saturating at 255. Predictor updates are hints, so loss is permitted.
- enqReady is derived from the registered count, so it is conservative: it ignores any same-cycle dequeue or coalescing.
- Intra-cycle merge (COALESCE=1): valid lanes with equal index collapse to the highest-numbered lane. The lower lanes are consumed and neither allocated nor counted as drops.
- Queue merge (COALESCE=1): a surviving lane whose index matches a valid queued entry overwrites that entry's value in place and allocates nothing. The head entry is excluded from matching when wrValid=1 in the same cycle; that lane allocates a new tail entry instead. At most one queued entry per index exists when COALESCE=1.
- Allocation: surviving non-merged lanes are written to consecutive tail slots in ascending lane order.
- Count update: count_next = count + allocated - (wrValid ? 1 : 0).
- Lookup: combinational over registered entries only; it does not see same-cycle enqueues. With COALESCE=0, the youngest match (nearest tail) wins.

## Timing
- Reset values: count=0, head=tail=0, all entry valid bits=0, dropCount=0. Resulting outputs: wrValid=0, empty=1, full=0, enqReady=1, lookupHit=0.
- Enqueue-to-visibility latency is 1 cycle. An entry accepted at edge N appears on lookup and, if it is the head, on wrValid after edge N.
- Minimum enqueue-to-RAM-write latency is 1 cycle with an empty queue and portBusy=0.
- Drain throughput is 1 entry per cycle while portBusy=0.
- Simultaneous enqueue and dequeue at full-minus-ENQ_WIDTH is legal, and count never exceeds DEPTH.
- rst asserted mid-operation discards all pending entries at the next edge and does not write them.
- With DEPTH==ENQ_WIDTH, enqReady is 1 only while empty.

## Test plan
- Reset, then one update (idx 5, val 3) with portBusy=0 -> the next cycle shows wrValid=1, wrIndex=5, wrValue=3; the cycle after shows empty=1.
- Hold portBusy=1 and issue 16 cycles of 2 distinct updates each (DEPTH=32) -> count=32, full=1, enqReady=0. A further 2-lane request gives dropCount=2. Release portBusy -> 32 writes in FIFO order over 32 cycles, with pointers wrapping.
- COALESCE=1: queue idx 7 val 1, then later idx 7 val 2 while stalled -> count stays 1 and lookupIndex=7 returns hit with value 2.
- Same cycle, lane0 idx 9 val 0 and lane1 idx 9 val 3 -> one entry allocated, value 3, dropCount unchanged.
- Head idx 4 draining (wrValid=1) while lane0 enqueues idx 4 val 2 -> the head writes its old value and a new tail entry idx 4 val 2 is allocated, so count is unchanged.
- Assert rst with 10 queued entries -> the next cycle shows count=0, wrValid=0, lookupHit=0, dropCount=0.
